// File: rtl/audio_pkg.sv
// Shared types and default sizing for the I2S transmit path.
package audio_pkg;

  localparam int unsigned AUDIO_DATA_W   = 24;
  localparam int unsigned AUDIO_SLOT_W   = 32;
  localparam int unsigned AUDIO_MCLK_DIV = 4;
  localparam int unsigned FRAME_CYCLES   = 2 * AUDIO_SLOT_W * AUDIO_MCLK_DIV;

  // Stereo samples are sized by AUDIO_DATA_W; the top's DATA_W must match it.
  typedef struct packed {
    logic [AUDIO_DATA_W-1:0] left;
    logic [AUDIO_DATA_W-1:0] right;
  } stereo_sample_t;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/i2s_tx_serializer_if.sv
// Sample stream, PLL lock and codec pin bundle for the I2S serializer.
interface i2s_tx_serializer_if #(
  parameter int unsigned DATA_W = 24
) ();

  logic              pll_locked;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;
  logic              bclk;
  logic              lrck;
  logic              sdata;
  logic              active;
  logic              underrun;
  logic [15:0]       underrun_cnt;

  modport master (
    output pll_locked,
    output s_valid,
    output s_left,
    output s_right,
    input  s_ready,
    input  bclk,
    input  lrck,
    input  sdata,
    input  active,
    input  underrun,
    input  underrun_cnt
  );

  modport slave (
    input  pll_locked,
    input  s_valid,
    input  s_left,
    input  s_right,
    output s_ready,
    output bclk,
    output lrck,
    output sdata,
    output active,
    output underrun,
    output underrun_cnt
  );

endinterface

// File: rtl/audio_sample_fifo.sv
// Synchronous FIFO of stereo samples; DEPTH must be a power of two (>= 2).
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_push,
  input  stereo_sample_t i_data,
  input  logic           i_pop,
  output stereo_sample_t o_data,
  output logic           o_full,
  output logic           o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(DEPTH);

  stereo_sample_t   r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_count == CntFull);
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: derives BCLK/LRCK from MCLK and shifts buffered stereo samples
// out MSB first, one BCLK after the word-select edge.
module i2s_tx_serializer
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W     = AUDIO_DATA_W,
  parameter int unsigned SLOT_W     = AUDIO_SLOT_W,
  parameter int unsigned MCLK_DIV   = AUDIO_MCLK_DIV,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  i2s_tx_serializer_if.slave io_bus
);

  localparam int unsigned DIV_W = $clog2(MCLK_DIV);
  localparam int unsigned BIT_W = $clog2(2 * SLOT_W);
  localparam int unsigned IDX_W = $clog2(DATA_W);

  localparam logic [DIV_W-1:0] DivLast = DIV_W'(MCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DivHalf = DIV_W'(MCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BitLast = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] BitSlot = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0] BitData = BIT_W'(DATA_W);

  logic              r_lock_meta;
  logic              r_lock_s;
  state_e            r_state;
  state_e            w_state_d;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [DIV_W-1:0]  w_div_d;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [BIT_W-1:0]  w_bit_d;
  logic              r_bclk;
  logic              w_bclk_d;
  logic              r_lrck;
  logic              w_lrck_d;
  logic              r_sdata;
  logic              w_sdata_d;
  logic [DATA_W-1:0] r_left;
  logic [DATA_W-1:0] w_left_d;
  logic [DATA_W-1:0] r_right;
  logic [DATA_W-1:0] w_right_d;
  logic              r_underrun;
  logic              w_underrun_d;
  logic [15:0]       r_underrun_cnt;
  logic [15:0]       w_underrun_cnt_d;
  logic              r_ready_en;

  logic              w_run;
  logic              w_entry;
  logic              w_fall;
  logic              w_wrap;
  logic              w_load;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [BIT_W-1:0]  w_k;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_chan;
  stereo_sample_t    w_in;
  stereo_sample_t    w_head;

  assign w_run   = (r_state == StRun) & r_lock_s;
  assign w_entry = (r_state == StIdle) & r_lock_s;
  assign w_fall  = w_run & (r_div_cnt == DivLast);
  assign w_wrap  = w_fall & (r_bit_cnt == BitLast);
  assign w_load  = w_entry | w_wrap;
  // Pop decision uses the pre-push occupancy, so a same-cycle push cannot cover an underrun.
  assign w_pop   = w_load & ~w_empty;
  assign w_push  = io_bus.s_valid & io_bus.s_ready;
  assign w_in    = '{left: io_bus.s_left, right: io_bus.s_right};

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: if (r_lock_s)  w_state_d = StRun;
      StRun:  if (!r_lock_s) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_div_d          = '0;
    w_bit_d          = '0;
    w_bclk_d         = 1'b0;
    w_lrck_d         = 1'b0;
    w_sdata_d        = 1'b0;
    w_left_d         = r_left;
    w_right_d        = r_right;
    w_underrun_d     = 1'b0;
    w_underrun_cnt_d = r_underrun_cnt;
    w_k              = '0;
    w_idx            = '0;
    w_chan           = '0;
    if (w_run) begin
      w_div_d   = w_fall ? '0 : r_div_cnt + DIV_W'(1);
      w_bit_d   = r_bit_cnt;
      w_lrck_d  = r_lrck;
      w_sdata_d = r_sdata;
      if (w_fall) begin
        w_bit_d  = w_wrap ? '0 : r_bit_cnt + BIT_W'(1);
        w_lrck_d = (w_bit_d >= BitSlot);
        w_k      = w_lrck_d ? w_bit_d - BitSlot : w_bit_d;
        w_chan   = w_lrck_d ? r_right : r_left;
        // Slot position 0 is the I2S one-bit delay; positions beyond DATA_W pad with zero.
        w_idx     = IDX_W'(BitData - w_k);
        w_sdata_d = (w_k != '0) && (w_k <= BitData) && w_chan[w_idx];
      end
      w_bclk_d = (w_div_d >= DivHalf);
    end
    if (w_load) begin
      w_left_d  = w_pop ? w_head.left : '0;
      w_right_d = w_pop ? w_head.right : '0;
      if (w_empty) begin
        w_underrun_d     = 1'b1;
        w_underrun_cnt_d = sat_inc16(r_underrun_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock_meta    <= 1'b0;
      r_lock_s       <= 1'b0;
      r_div_cnt      <= '0;
      r_bit_cnt      <= '0;
      r_bclk         <= 1'b0;
      r_lrck         <= 1'b0;
      r_sdata        <= 1'b0;
      r_left         <= '0;
      r_right        <= '0;
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
      r_ready_en     <= 1'b0;
    end else begin
      r_lock_meta    <= io_bus.pll_locked;
      r_lock_s       <= r_lock_meta;
      r_div_cnt      <= w_div_d;
      r_bit_cnt      <= w_bit_d;
      r_bclk         <= w_bclk_d;
      r_lrck         <= w_lrck_d;
      r_sdata        <= w_sdata_d;
      r_left         <= w_left_d;
      r_right        <= w_right_d;
      r_underrun     <= w_underrun_d;
      r_underrun_cnt <= w_underrun_cnt_d;
      r_ready_en     <= 1'b1;
    end
  end

  assign io_bus.s_ready      = r_ready_en & ~w_full;
  assign io_bus.bclk         = r_bclk;
  assign io_bus.lrck         = r_lrck;
  assign io_bus.sdata        = r_sdata;
  assign io_bus.active       = (r_state == StRun);
  assign io_bus.underrun     = r_underrun;
  assign io_bus.underrun_cnt = r_underrun_cnt;

endmodule
